// File: rtl/jpeg_fb_arbiter.sv
// Frame-buffer port scheduler: MCU-order decoder writes vs raster reads, round-robin on conflict.
// Writes/read issue combinationally in the grant cycle, read data 1 cycle later; decoder stalled via bi_next.
module jpeg_fb_arbiter #(
    parameter int AW = 20,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    cfg_blk_w,
    input  logic          bo_we,
    output logic          bi_next,
    input  logic          bo_begin,
    input  logic          bo_end,
    input  logic [31:0]   bo_data,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          frame_done,
    output logic          busy
);

    logic          prio_wr;
    logic [3:0]    px, py;
    logic [7:0]    bx, by;
    logic [7:0]    blk_w;
    logic [AW-1:0] row_base;
    logic [AW-1:0] mcu_base;
    logic [12:0]   stride13;
    logic [AW-1:0] stride;
    logic [AW-1:0] mcu_stride;
    logic [AW-1:0] wr_addr;
    logic          wr_acc;
    logic          start;
    logic          unused_bits;

    assign unused_bits = ^bo_data[7:0];

    assign bi_next = ~rd_req | prio_wr;
    assign rd_gnt  = rd_req & ~(bo_we & prio_wr);
    assign wr_acc  = bo_we & bi_next;
    assign start   = ~busy | bo_begin;

    // blk_w of 0 encodes 256 MCUs, i.e. a 4096-pixel stride
    assign stride13   = {(blk_w == 8'd0), blk_w, 4'b0000};
    assign stride     = AW'(stride13);
    assign mcu_stride = AW'({stride13, 4'b0000});

    // row_base tracks (by*16+py)*S incrementally; mcu_base tracks by*16*S
    assign wr_addr = start ? '0 : row_base + AW'({bx, 4'b0000}) + AW'(px);

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = rd_addr;
        mem_wdata = bo_data[31:8];
        if (wr_acc) begin
            mem_en   = 1'b1;
            mem_wr   = 1'b1;
            mem_addr = wr_addr;
        end else if (rd_gnt) begin
            mem_en = 1'b1;
        end
    end

    assign rd_data = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_wr    <= 1'b1;
            rd_valid   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            px         <= '0;
            py         <= '0;
            bx         <= '0;
            by         <= '0;
            blk_w      <= '0;
            row_base   <= '0;
            mcu_base   <= '0;
        end else begin
            rd_valid   <= rd_gnt;
            frame_done <= wr_acc & bo_end;
            if (bo_we & rd_req)
                prio_wr <= ~prio_wr;
            if (wr_acc) begin
                if (bo_end) begin
                    busy     <= 1'b0;
                    px       <= '0;
                    py       <= '0;
                    bx       <= '0;
                    by       <= '0;
                    row_base <= '0;
                    mcu_base <= '0;
                end else if (start) begin
                    // the start pixel itself lands at 0, so the next one is px=1
                    busy     <= 1'b1;
                    blk_w    <= cfg_blk_w;
                    px       <= 4'd1;
                    py       <= '0;
                    bx       <= '0;
                    by       <= '0;
                    row_base <= '0;
                    mcu_base <= '0;
                end else if (px != 4'd15) begin
                    px <= px + 4'd1;
                end else begin
                    px <= '0;
                    if (py != 4'd15) begin
                        py       <= py + 4'd1;
                        row_base <= row_base + stride;
                    end else begin
                        py <= '0;
                        if (bx != blk_w - 8'd1) begin
                            bx       <= bx + 8'd1;
                            row_base <= mcu_base;
                        end else begin
                            bx       <= '0;
                            by       <= by + 8'd1;
                            mcu_base <= mcu_base + mcu_stride;
                            row_base <= mcu_base + mcu_stride;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jpeg_fb_arbiter.sv
module tb_jpeg_fb_arbiter;
    localparam int AW = 20;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    cfg_blk_w;
    logic          bo_we, bi_next, bo_begin, bo_end;
    logic [31:0]   bo_data;
    logic          rd_req, rd_gnt, rd_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          frame_done, busy;

    always #5 clk = ~clk;

    jpeg_fb_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .cfg_blk_w(cfg_blk_w),
        .bo_we(bo_we), .bi_next(bi_next), .bo_begin(bo_begin), .bo_end(bo_end),
        .bo_data(bo_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .frame_done(frame_done), .busy(busy)
    );

    function automatic logic [DW-1:0] mem_hash(input logic [AW-1:0] a);
        return {a[3:0] ^ 4'h5, a} ^ 24'h3C5A69;
    endfunction

    // Memory stand-in: read data depends on the address read the cycle before.
    always @(posedge clk)
        mem_rdata <= (mem_en && !mem_wr) ? mem_hash(mem_addr) : DW'($urandom);

    // Reference model: frame-relative pixel index plus frame width in MCUs.
    int            m_idx = 0;
    int            m_w = 1;
    bit            m_busy = 0, m_prio = 1, m_rdv = 0, m_done = 0;
    logic [DW-1:0] m_rdexp = '0;
    bit            s_wr, s_g, s_start;
    bit            chk_en = 0;
    int            checks = 0, errors = 0;

    function automatic int ref_addr(input int k, input int w);
        int mcu, inb, bxx, byy;
        mcu = k / 256;
        inb = k % 256;
        bxx = mcu % w;
        byy = mcu / w;
        return ((byy * 16 + inb / 16) * 16 * w + bxx * 16 + inb % 16) % (1 << AW);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        s_g     = rd_req && !(bo_we && m_prio);
        s_wr    = bo_we && (!rd_req || m_prio);
        s_start = !m_busy || bo_begin;
        if (chk_en) begin
            chk("bi_next", bi_next, !rd_req || m_prio);
            chk("rd_gnt", rd_gnt, s_g);
            chk("mem_en", mem_en, s_wr || s_g);
            if (s_wr) begin
                chk("mem_wr", mem_wr, 1);
                chk("wr_addr", mem_addr, s_start ? 0 : ref_addr(m_idx, m_w));
                chk("wdata", mem_wdata, bo_data[31:8]);
            end else if (s_g) begin
                chk("mem_wr", mem_wr, 0);
                chk("rd_addr", mem_addr, rd_addr);
            end
            chk("rd_valid", rd_valid, m_rdv);
            if (m_rdv) chk("rd_data", rd_data, m_rdexp);
            chk("frame_done", frame_done, m_done);
            chk("busy", busy, m_busy);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_idx = 0; m_busy = 0; m_prio = 1; m_rdv = 0; m_done = 0;
        end else begin
            m_rdv = s_g;
            if (s_g) m_rdexp = mem_hash(rd_addr);
            m_done = s_wr && bo_end;
            if (bo_we && rd_req) m_prio = s_wr ? 1'b0 : 1'b1;
            if (s_wr) begin
                if (s_start) begin
                    m_w = (cfg_blk_w == 0) ? 256 : int'(cfg_blk_w);
                    m_idx = 1;
                end else begin
                    m_idx++;
                end
                if (bo_end) begin
                    m_busy = 0; m_idx = 0;
                end else begin
                    m_busy = 1;
                end
            end
        end
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic drive(input bit we, input bit rq, input bit b, input bit e);
        bo_we = we; rd_req = rq; bo_begin = b; bo_end = e;
        bo_data = $urandom;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        rst = 1;
        step();
        rst = 0;
    endtask

    typedef struct {
        bit we, rq;
        bit exp_bn, exp_g, exp_en, exp_wr, exp_rdv;
    } vec_t;

    vec_t vecs[11];
    int   t1_idx[6];
    int   t1_exp[6];

    initial begin
        vecs[0]  = '{1, 1, 1, 0, 1, 1, 0};
        vecs[1]  = '{1, 1, 0, 1, 1, 0, 0};
        vecs[2]  = '{1, 1, 1, 0, 1, 1, 1};
        vecs[3]  = '{1, 1, 0, 1, 1, 0, 0};
        vecs[4]  = '{0, 1, 1, 1, 1, 0, 1};
        vecs[5]  = '{0, 0, 1, 0, 0, 0, 1};
        vecs[6]  = '{1, 0, 1, 0, 1, 1, 0};
        vecs[7]  = '{0, 1, 1, 1, 1, 0, 0};
        vecs[8]  = '{1, 1, 1, 0, 1, 1, 1};
        vecs[9]  = '{0, 1, 0, 1, 1, 0, 0};
        vecs[10] = '{0, 0, 1, 0, 0, 0, 1};
        t1_idx = '{0, 15, 16, 255, 256, 512};
        t1_exp = '{0, 15, 32, 495, 16, 512};

        rst = 1; cfg_blk_w = 8'd2; rd_addr = 20'h00100;
        drive(0, 0, 0, 0);
        advance(); advance();
        rst = 0;
        chk_en = 1;

        // Reset state and arbitration table
        sample();
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_bn", bi_next, 1);
        advance();
        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].rq, 0, 0);
            rd_addr = 20'h00100;
            sample();
            chk($sformatf("vec%0d_bn", i), bi_next, vecs[i].exp_bn);
            chk($sformatf("vec%0d_gnt", i), rd_gnt, vecs[i].exp_g);
            chk($sformatf("vec%0d_en", i), mem_en, vecs[i].exp_en);
            chk($sformatf("vec%0d_rdv", i), rd_valid, vecs[i].exp_rdv);
            if (vecs[i].exp_en) chk($sformatf("vec%0d_wr", i), mem_wr, vecs[i].exp_wr);
            if (vecs[i].exp_g) chk($sformatf("vec%0d_addr", i), mem_addr, 20'h00100);
            advance();
        end

        // Stride-32 address pattern
        do_reset();
        cfg_blk_w = 8'd2;
        for (int k = 0; k <= 600; k++) begin
            drive(1, 0, 0, k == 600);
            sample();
            foreach (t1_idx[j])
                if (t1_idx[j] == k) chk($sformatf("t1_px%0d", k), mem_addr, t1_exp[j]);
            advance();
        end
        drive(0, 0, 0, 0);
        sample();
        chk("t1_done", frame_done, 1);
        chk("t1_busy", busy, 0);
        advance();

        // Reset in the middle of a frame
        for (int k = 0; k < 300; k++) begin
            drive(1, 0, 0, 0);
            step();
        end
        do_reset();
        drive(1, 0, 0, 0);
        sample();
        chk("t5_addr", mem_addr, 0);
        advance();
        drive(0, 0, 0, 0);
        sample();
        chk("t5_busy", busy, 1);
        advance();

        // Width change mid-frame applies only to the next frame
        do_reset();
        cfg_blk_w = 8'd2;
        for (int k = 0; k <= 600; k++) begin
            if (k == 100) cfg_blk_w = 8'd4;
            drive(1, 0, 0, k == 600);
            sample();
            if (k == 512) chk("t6_old_stride", mem_addr, 512);
            advance();
        end
        for (int k = 0; k <= 20; k++) begin
            drive(1, 0, 0, k == 20);
            sample();
            if (k == 16) chk("t6_new_stride", mem_addr, 64);
            advance();
        end

        // Wide picture, mid-frame restart, one-pixel frame
        do_reset();
        cfg_blk_w = 8'd61;
        for (int k = 0; k <= 15620; k++) begin
            drive(1, 0, 0, k == 15620);
            sample();
            if (k == 15616) chk("t2_blk61", mem_addr, 15616);
            advance();
        end
        drive(0, 0, 0, 0);
        sample();
        chk("t2_done", frame_done, 1);
        chk("t2_busy", busy, 0);
        advance();
        sample();
        chk("t2_done_clr", frame_done, 0);
        advance();
        for (int k = 0; k < 50; k++) begin
            drive(1, 0, k == 40, 0);
            sample();
            if (k == 40) chk("restart_addr", mem_addr, 0);
            if (k == 41) chk("restart_next", mem_addr, 1);
            advance();
        end
        drive(1, 0, 1, 1);
        sample();
        chk("one_px_addr", mem_addr, 0);
        advance();
        drive(0, 0, 0, 0);
        sample();
        chk("one_px_done", frame_done, 1);
        chk("one_px_busy", busy, 0);
        advance();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom % 4) != 0, ($urandom % 3) == 0,
                  ($urandom % 200) == 0, ($urandom % 150) == 0);
            cfg_blk_w = 8'($urandom_range(0, 4));
            rd_addr = AW'($urandom);
            rst = (($urandom % 500) == 0);
            step();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
